// File: rtl/wptr_full_ctrl_pkg.sv
// Shared async-FIFO helpers: Gray encode/decode and the default address width.
package wptr_full_ctrl_pkg;

  localparam int DEF_ADDRSIZE = 8;

  // Gray encode. Works for any pointer width up to 32 as long as unused MSBs are zero.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Gray decode. Each binary bit is the XOR of all Gray bits at or above it.
  // Zero upper bits leave narrower pointers unaffected.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_sync_r2w.sv
// Two-flop synchronizer for a Gray pointer crossing into another clock domain.
module sync_r2w
  import wptr_full_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_ADDRSIZE + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q1, r_q2;

  // Two metastability-settling stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, fill level and full/almost-full/overflow flags of an async FIFO.
module wptr_full_ctrl
  import wptr_full_ctrl_pkg::*;
#(
  parameter int ADDRSIZE     = DEF_ADDRSIZE,
  parameter int AFULL_THRESH = (1 << ADDRSIZE) - 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr_async,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);

  logic [PW-1:0] r_wbin, r_wptr, r_wlevel;
  logic          r_wfull, r_walmost_full, r_woverflow;

  logic [PW-1:0] w_wq2_rptr, w_rbin_sync, w_wbinnext, w_wgraynext, w_levelnext, w_full_ptr;
  logic          w_wen;

  sync_r2w #(.WIDTH(PW)) u_sync_r2w (
    .clk   (wclk),
    .rst_n (wrst_n),
    .i_d   (rptr_async),
    .o_q   (w_wq2_rptr)
  );

  // A write while full is dropped here, so pointers and level hold.
  assign w_wen       = winc & ~r_wfull;
  assign w_wbinnext  = r_wbin + PW'(w_wen);
  assign w_wgraynext = PW'(bin2gray(32'(w_wbinnext)));
  assign w_rbin_sync = PW'(gray2bin(32'(w_wq2_rptr)));
  assign w_levelnext = w_wbinnext - w_rbin_sync;
  // Full: write pointer has lapped the read pointer exactly once (top two Gray bits inverted).
  assign w_full_ptr  = {~w_wq2_rptr[PW-1:PW-2], w_wq2_rptr[PW-3:0]};

  // Pointer and flag registers; flags use the post-write pointer so the filling write sets full.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wlevel       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_wbinnext;
      r_wptr         <= w_wgraynext;
      r_wlevel       <= w_levelnext;
      r_wfull        <= (w_wgraynext == w_full_ptr);
      r_walmost_full <= (w_levelnext >= AF_T);
      r_woverflow    <= r_woverflow | (winc & r_wfull);
    end
  end

  assign wen          = w_wen;
  assign waddr        = r_wbin[ADDRSIZE-1:0];
  assign wptr         = r_wptr;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
  assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl with ADDRSIZE=4, AFULL_THRESH=12.
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b1;
  logic       winc = 1'b0;
  logic [4:0] rptr_async = '0;
  logic       wen, wfull, walmost_full, woverflow;
  logic [3:0] waddr;
  logic [4:0] wptr, wlevel;

  int total = 0;
  int bad   = 0;

  always #5 wclk = ~wclk;

  wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .rptr_async   (rptr_async),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  typedef struct {
    logic       winc;
    logic [4:0] rptr;
    logic       e_wen;
    logic       e_full;
    logic       e_af;
    logic [4:0] e_lvl;
    logic [4:0] e_wptr;
    logic [3:0] e_waddr;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[$];

  // Hand-computed Gray codes of 0..16.
  logic [4:0] gk[17] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111,
                         5'b00101, 5'b00100, 5'b01100, 5'b01101, 5'b01111, 5'b01110,
                         5'b01010, 5'b01011, 5'b01001, 5'b01000, 5'b11000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic inc, input logic [4:0] rp);
    winc = inc;
    rptr_async = rp;
    @(posedge wclk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    winc = v.winc;
    rptr_async = v.rptr;
    #1;
    chk({t, ".wen"}, 32'(wen), 32'(v.e_wen));
    @(posedge wclk);
    #1;
    chk({t, ".wfull"}, 32'(wfull), 32'(v.e_full));
    chk({t, ".afull"}, 32'(walmost_full), 32'(v.e_af));
    chk({t, ".wlevel"}, 32'(wlevel), 32'(v.e_lvl));
    chk({t, ".wptr"}, 32'(wptr), 32'(v.e_wptr));
    chk({t, ".waddr"}, 32'(waddr), 32'(v.e_waddr));
    chk({t, ".wovf"}, 32'(woverflow), 32'(v.e_ovf));
  endtask

  task automatic pulse_reset();
    wrst_n = 1'b0;
    winc = 1'b0;
    rptr_async = '0;
    #1;
    wrst_n = 1'b1;
  endtask

  function automatic logic [4:0] tb_b2g(input logic [4:0] b);
    return b ^ {1'b0, b[4:1]};
  endfunction

  function automatic logic [4:0] tb_g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] m_wbin, m_q1, m_q2, m_lvl, rd, occ;
    logic       m_full, m_wen;

    // Power-on reset
    #2 wrst_n = 1'b0;
    #1;
    chk("por.wptr", 32'(wptr), 0);
    chk("por.wlevel", 32'(wlevel), 0);
    chk("por.wfull", 32'(wfull), 0);
    chk("por.wovf", 32'(woverflow), 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;

    // Burst to wbin=7, then async reset with no clock edge
    repeat (7) cyc(1'b1, 5'd0);
    chk("burst.waddr", 32'(waddr), 7);
    chk("burst.wptr", 32'(wptr), 32'(5'b00100));
    chk("burst.wlevel", 32'(wlevel), 7);
    wrst_n = 1'b0;
    winc = 1'b0;
    #1;
    chk("rst.waddr", 32'(waddr), 0);
    chk("rst.wptr", 32'(wptr), 0);
    chk("rst.wlevel", 32'(wlevel), 0);
    chk("rst.wfull", 32'(wfull), 0);
    chk("rst.afull", 32'(walmost_full), 0);
    chk("rst.wovf", 32'(woverflow), 0);
    chk("rst.wen", 32'(wen), 0);
    #1 wrst_n = 1'b1;

    // Fill, overflow and idle table
    for (int k = 1; k <= 16; k++)
      tbl.push_back('{1'b1, 5'd0, 1'b1, (k == 16), (k >= 12), 5'(k), gk[k], 4'(k), 1'b0});
    repeat (3) tbl.push_back('{1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd16, 5'b11000, 4'd0, 1'b1});
    tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd16, 5'b11000, 4'd0, 1'b1});
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Drain visibility: read pointer advance seen after the third edge
    cyc(1'b0, 5'b00001);
    chk("drain.e1.wfull", 32'(wfull), 1);
    chk("drain.e1.afull", 32'(walmost_full), 1);
    cyc(1'b0, 5'b00001);
    chk("drain.e2.wfull", 32'(wfull), 1);
    chk("drain.e2.wlevel", 32'(wlevel), 16);
    cyc(1'b0, 5'b00001);
    chk("drain.e3.wfull", 32'(wfull), 0);
    chk("drain.e3.wlevel", 32'(wlevel), 15);
    chk("drain.e3.afull", 32'(walmost_full), 1);
    winc = 1'b1;
    #1;
    chk("drain.wen", 32'(wen), 1);
    @(posedge wclk);
    #1;
    chk("drain.refill.wfull", 32'(wfull), 1);
    chk("drain.refill.wlevel", 32'(wlevel), 16);
    chk("drain.refill.wptr", 32'(wptr), 32'(5'b11001));
    chk("drain.refill.waddr", 32'(waddr), 1);
    chk("drain.wovf_sticky", 32'(woverflow), 1);
    winc = 1'b0;
    wrst_n = 1'b0;
    #1;
    chk("ovf.rst_clear", 32'(woverflow), 0);
    #1 wrst_n = 1'b1;

    // Wrap: reach wbin=16 with reader at 16, then 16 more writes
    repeat (16) cyc(1'b1, 5'd0);
    repeat (3) cyc(1'b0, 5'b11000);
    chk("wrap.empty.wlevel", 32'(wlevel), 0);
    chk("wrap.empty.wfull", 32'(wfull), 0);
    chk("wrap.empty.afull", 32'(walmost_full), 0);
    chk("wrap.empty.wptr", 32'(wptr), 32'(5'b11000));
    repeat (8) cyc(1'b1, 5'b11000);
    chk("wrap.mid.wlevel", 32'(wlevel), 8);
    chk("wrap.mid.wptr", 32'(wptr), 32'(5'b10100));
    repeat (8) cyc(1'b1, 5'b11000);
    chk("wrap.end.wptr", 32'(wptr), 0);
    chk("wrap.end.waddr", 32'(waddr), 0);
    chk("wrap.end.wfull", 32'(wfull), 1);
    chk("wrap.end.wlevel", 32'(wlevel), 16);

    // Simultaneous write and read advance, checked against a small occupancy model
    pulse_reset();
    repeat (16) cyc(1'b1, 5'd0);
    m_wbin = 5'd16; m_q1 = '0; m_q2 = '0; m_full = 1'b1;
    for (int c = 0; c < 28; c++) begin
      rd = (c < 3) ? 5'd0 : (c <= 22) ? 5'(c - 2) : 5'd20;
      m_wen = ~m_full;
      cyc(1'b1, tb_b2g(rd));
      m_wbin = m_wbin + 5'(m_wen);
      m_lvl  = m_wbin - tb_g2b(m_q2);
      m_full = (m_lvl == 5'd16);
      m_q2   = m_q1;
      m_q1   = tb_b2g(rd);
      occ    = m_wbin - rd;
      chk($sformatf("sim%0d.wfull", c), 32'(wfull), 32'(m_full));
      chk($sformatf("sim%0d.wlevel", c), 32'(wlevel), 32'(m_lvl));
      chk($sformatf("sim%0d.lvl_le16", c), 32'(wlevel <= 5'd16), 1);
      if (occ == 5'd16) chk($sformatf("sim%0d.full_at_occ16", c), 32'(wfull), 1);
    end
    winc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
